// File: rtl/mdu_iter_pkg.sv
// Shared MDU op encodings, FSM states and op-class helpers.
// Defining MDU_ACC_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops.
package mdu_iter_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;
  localparam logic [3:0] MDU_MADD  = 4'd7;
  localparam logic [3:0] MDU_MADDU = 4'd8;
  localparam logic [3:0] MDU_MSUB  = 4'd9;
  localparam logic [3:0] MDU_MSUBU = 4'd10;

`ifdef MDU_ACC_EN
  localparam logic ACC_EN = 1'b1;
`else
  localparam logic ACC_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV_ITER,
    S_DIV_FIX,
    S_WAIT
  } mdu_state_e;

  function automatic logic is_acc(input logic [3:0] op);
    return ACC_EN & (op inside {MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU});
  endfunction

  function automatic logic is_mul(input logic [3:0] op);
    return (op inside {MDU_MULT, MDU_MULTU}) | is_acc(op);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return op inside {MDU_DIV, MDU_DIVU};
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    return op inside {MDU_MULT, MDU_DIV, MDU_MADD, MDU_MSUB};
  endfunction

  function automatic logic is_sub(input logic [3:0] op);
    return op inside {MDU_MSUB, MDU_MSUBU};
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Iterative restoring divider on unsigned magnitudes, one quotient bit per cycle.
// The first step is taken on the load edge; done pulses once the last bit is in.
module mdu_div_core
  import mdu_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             run_q, run_d, done_q, done_d;
  logic [2*WIDTH-1:0] nxt;

  // Shift in the next dividend bit, subtract if it fits, record the quotient bit.
  function automatic logic [2*WIDTH-1:0] step(input logic [WIDTH-1:0] rem,
                                               input logic [WIDTH-1:0] quo,
                                               input logic [WIDTH-1:0] dvs);
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;
    shifted = {rem, quo[WIDTH-1]};
    ge      = shifted >= {1'b0, dvs};
    diff    = shifted[WIDTH-1:0] - dvs;
    return {(ge ? diff : shifted[WIDTH-1:0]), quo[WIDTH-2:0], ge};
  endfunction

  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;
    nxt    = '0;
    if (start) begin
      nxt            = step('0, dividend, divisor);
      {rem_d, quo_d} = nxt;
      dvs_d          = divisor;
      cnt_d          = CW'(1);
      run_d          = 1'b1;
    end else if (run_q) begin
      nxt            = step(rem_q, quo_q, dvs_q);
      {rem_d, quo_d} = nxt;
      cnt_d          = cnt_q + 1'b1;
      if (cnt_q == CW'(WIDTH - 1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/mdu_iter.sv
// Execute-stage multiply/divide unit owning HI/LO; fixed-latency multiply, iterative divide.
// MDU_ACC_EN adds the accumulate ops (MADD/MADDU/MSUB/MSUBU) on the multiply timing.
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 5,
  parameter int DIV_LATENCY = 33
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             stall,
  output logic             busy,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  if (DIV_LATENCY < WIDTH + 1) begin : g_bad_div_latency
    $error("mdu_iter: DIV_LATENCY must be at least WIDTH+1");
  end
  if (MUL_LATENCY < 1) begin : g_bad_mul_latency
    $error("mdu_iter: MUL_LATENCY must be at least 1");
  end

  localparam int CNT_W = $clog2(DIV_LATENCY + MUL_LATENCY + 2);

  mdu_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d, dz_q, dz_d, dz_pend_q, dz_pend_d;
  logic               acc_q, acc_d, sub_q, sub_d, neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic               sgn, a_neg, b_neg, div_go, core_done;
  logic [WIDTH-1:0]   dvd_mag, dvs_mag, core_quo, core_rem, fix_quo, fix_rem;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod_now, mul_res;

  always_comb begin
    sgn      = is_signed_op(op);
    a_neg    = sgn & rs_data[WIDTH-1];
    b_neg    = sgn & rt_data[WIDTH-1];
    dvd_mag  = a_neg ? -rs_data : rs_data;
    dvs_mag  = b_neg ? -rt_data : rt_data;
    a_ext    = a_neg ? {{WIDTH{1'b1}}, rs_data} : {{WIDTH{1'b0}}, rs_data};
    b_ext    = b_neg ? {{WIDTH{1'b1}}, rt_data} : {{WIDTH{1'b0}}, rt_data};
    prod_now = a_ext * b_ext;
    div_go   = (state_q == S_IDLE) & start & is_div(op) & (rt_data != '0);
    // Accumulate reads the live HI/LO at the commit edge, not at issue.
    mul_res  = !acc_q ? prod_q : sub_q ? ({hi_q, lo_q} - prod_q) : ({hi_q, lo_q} + prod_q);
    fix_quo  = neg_quo_q ? -core_quo : core_quo;
    fix_rem  = neg_rem_q ? -core_rem : core_rem;
  end

  mdu_div_core #(.WIDTH(WIDTH)) u_div_core (
    .clk       (clk),
    .reset     (reset),
    .start     (div_go),
    .dividend  (dvd_mag),
    .divisor   (dvs_mag),
    .done      (core_done),
    .quotient  (core_quo),
    .remainder (core_rem)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    dz_d      = dz_q;
    dz_pend_d = dz_pend_q;
    acc_d     = acc_q;
    sub_d     = sub_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    res_hi_d  = res_hi_q;
    res_lo_d  = res_lo_q;
    prod_d    = prod_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && is_mul(op)) begin
          prod_d  = prod_now;
          acc_d   = is_acc(op);
          sub_d   = is_sub(op);
          busy_d  = 1'b1;
          cnt_d   = CNT_W'(1);
          state_d = S_MUL;
        end else if (start && is_div(op)) begin
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          busy_d    = 1'b1;
          cnt_d     = CNT_W'(1);
          dz_pend_d = (rt_data == '0);
          res_lo_d  = '1;
          res_hi_d  = rs_data;
          state_d   = (rt_data == '0) ? S_WAIT : S_DIV_ITER;
        end else if (op == MDU_MTHI) begin
          hi_d = rs_data;
        end else if (op == MDU_MTLO) begin
          lo_d = rs_data;
        end
      end
      S_MUL: begin
        if (cnt_q == CNT_W'(MUL_LATENCY)) begin
          {hi_d, lo_d} = mul_res;
          busy_d       = 1'b0;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DIV_ITER: begin
        cnt_d = cnt_q + 1'b1;
        if (core_done) state_d = S_DIV_FIX;
      end
      S_DIV_FIX: begin
        // At the minimum latency the fixed-up result commits straight from here.
        if (cnt_q == CNT_W'(DIV_LATENCY)) begin
          lo_d    = fix_quo;
          hi_d    = fix_rem;
          dz_d    = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          res_lo_d = fix_quo;
          res_hi_d = fix_rem;
          cnt_d    = cnt_q + 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(DIV_LATENCY)) begin
          lo_d    = res_lo_q;
          hi_d    = res_hi_q;
          dz_d    = dz_pend_q;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      dz_q      <= 1'b0;
      dz_pend_q <= 1'b0;
      acc_q     <= 1'b0;
      sub_q     <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      res_hi_q  <= '0;
      res_lo_q  <= '0;
      prod_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      dz_q      <= dz_d;
      dz_pend_q <= dz_pend_d;
      acc_q     <= acc_d;
      sub_q     <= sub_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      res_hi_q  <= res_hi_d;
      res_lo_q  <= res_lo_d;
      prod_q    <= prod_d;
    end
  end

  assign stall    = busy_q | (start & (is_mul(op) | is_div(op)));
  assign busy     = busy_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: hand-computed HI/LO, busy lengths, stall and reset behaviour.
// With MDU_ACC_EN defined the accumulate path is exercised; otherwise MADD must be inert.
module tb_mdu_iter;
  import mdu_iter_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = MDU_NONE;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        stall, busy, div_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  mdu_iter #(.WIDTH(32), .MUL_LATENCY(5), .DIV_LATENCY(33)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .stall    (stall),
    .busy     (busy),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one mul/div op, optionally inject a second op at busy cycle inj_at, count busy cycles.
  task automatic run_op(input string name, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int exp_busy, input int inj_at,
                        input logic inj_start, input logic [3:0] inj_op, input logic [31:0] inj_rs);
    int n;
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    #1 check({name, "_stall_issue"}, 64'(stall), 64'd1);
    @(negedge clk);
    start = 1'b0; op = MDU_NONE;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      if (n == inj_at) begin
        start = inj_start; op = inj_op; rs_data = inj_rs; rt_data = 32'd4;
        #1 check({name, "_stall_busy"}, 64'(stall), 64'd1);
      end
      @(negedge clk);
      start = 1'b0; op = MDU_NONE;
    end
    check({name, "_busy_cycles"}, 64'(n), 64'(exp_busy));
    $display("op %-8s rs=%h rt=%h busy=%0d -> hi=%h lo=%h dz=%0b", name, a, b, n, hi, lo, div_zero);
  endtask

  // Single-cycle op with no expected stall (mthi/mtlo, none, undefined, disabled ops).
  task automatic quiet_op(input string name, input logic st, input logic [3:0] o,
                          input logic [31:0] a);
    @(negedge clk);
    start = st; op = o; rs_data = a; rt_data = 32'd3;
    #1 check({name, "_stall"}, 64'(stall), 64'd0);
    @(negedge clk);
    start = 1'b0; op = MDU_NONE;
    check({name, "_busy"}, 64'(busy), 64'd0);
    $display("op %-8s start=%0b rs=%h -> hi=%h lo=%h", name, st, a, hi, lo);
  endtask

  task automatic check_hilo(input string name, input logic [31:0] eh, input logic [31:0] el);
    check({name, "_hi"}, 64'(hi), 64'(eh));
    check({name, "_lo"}, 64'(lo), 64'(el));
  endtask

  initial begin
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_hilo("reset", 32'h0, 32'h0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_dz", 64'(div_zero), 64'd0);
    check("reset_stall", 64'(stall), 64'd0);
    reset = 1'b1;

    run_op("mult", MDU_MULT, 32'hFFFFFFFE, 32'd3, 5, 0, 1'b0, MDU_NONE, 32'h0);
    check_hilo("mult", 32'hFFFFFFFF, 32'hFFFFFFFA);

    run_op("multu", MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 0, 1'b0, MDU_NONE, 32'h0);
    check_hilo("multu", 32'hFFFFFFFE, 32'h00000001);

    run_op("div_neg", MDU_DIV, 32'hFFFFFFF9, 32'd2, 33, 0, 1'b0, MDU_NONE, 32'h0);
    check_hilo("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD);
    check("div_neg_dz", 64'(div_zero), 64'd0);

    run_op("div_negb", MDU_DIV, 32'd7, 32'hFFFFFFFE, 33, 0, 1'b0, MDU_NONE, 32'h0);
    check_hilo("div_negb", 32'h00000001, 32'hFFFFFFFD);

    run_op("divu_z", MDU_DIVU, 32'h12345678, 32'h0, 33, 0, 1'b0, MDU_NONE, 32'h0);
    check_hilo("divu_z", 32'h12345678, 32'hFFFFFFFF);
    check("divu_z_dz", 64'(div_zero), 64'd1);

    run_op("div_ovf", MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 33, 10, 1'b1, MDU_MULTU, 32'd3);
    check_hilo("div_ovf", 32'h00000000, 32'h80000000);
    check("div_ovf_dz", 64'(div_zero), 64'd0);
    repeat (8) @(negedge clk);
    check("ignored_multu_busy", 64'(busy), 64'd0);
    check_hilo("ignored_multu", 32'h00000000, 32'h80000000);

    run_op("mult_mthi", MDU_MULT, 32'd2, 32'd3, 5, 2, 1'b0, MDU_MTHI, 32'hAAAA0000);
    check_hilo("mthi_busy", 32'h00000000, 32'h00000006);
    quiet_op("mthi", 1'b0, MDU_MTHI, 32'h00000001);
    check_hilo("mthi_idle", 32'h00000001, 32'h00000006);
    quiet_op("mtlo", 1'b1, MDU_MTLO, 32'hFFFFFFFF);
    check_hilo("mtlo_idle", 32'h00000001, 32'hFFFFFFFF);

`ifdef MDU_ACC_EN
    run_op("madd", MDU_MADD, 32'd2, 32'd3, 5, 0, 1'b0, MDU_NONE, 32'h0);
    check_hilo("madd", 32'h00000002, 32'h00000005);
`else
    quiet_op("madd_off", 1'b1, MDU_MADD, 32'd2);
    check_hilo("madd_off", 32'h00000001, 32'hFFFFFFFF);
`endif

    quiet_op("none", 1'b1, MDU_NONE, 32'h5);
    quiet_op("undef", 1'b1, 4'hF, 32'h5);

    // Reset lands mid-divide, away from any clock edge.
    @(negedge clk);
    start = 1'b1; op = MDU_DIVU; rs_data = 32'd100; rt_data = 32'd7;
    @(negedge clk);
    start = 1'b0; op = MDU_NONE;
    repeat (9) @(negedge clk);
    check("rst_pre_busy", 64'(busy), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("rst_async_busy", 64'(busy), 64'd0);
    check_hilo("rst_async", 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    check("rst_after_busy", 64'(busy), 64'd0);
    check_hilo("rst_after", 32'h0, 32'h0);
    $display("op reset-mid-divu -> hi=%h lo=%h busy=%0b", hi, lo, busy);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
